butterfly_pipe: RTL and testbench

- Parametrised, fully pipelined radix-2 DIT butterfly with valid/ready flow control: y0 = x0 + W·x1, y1 = x0 − W·x1.
- Twiddle product is rounded (not truncated). Optional per-transaction divide-by-2 scaling prevents bit growth across FFT stages.
- Sits between the stage commutator/delay-line and the next stage in the 256-point FFT datapath; replaces the fixed-width, unregistered-x0 butterfly in new stages.

---
 rtl/bfly_pkg.sv | 23 ++
 rtl/bfly_cmul.sv | 63 ++++++
 rtl/butterfly_pipe.sv | 141 ++++++++++++++
 tb/tb_butterfly_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bfly_pkg.sv
// Shared helpers for the radix-2 butterfly: latency, rounding constant, saturation.
package bfly_pkg;

    function automatic int latency(input int mul_stages);
        return mul_stages + 2;
    endfunction

    // Half an LSB of the twiddle scale, added before the arithmetic shift.
    function automatic logic [63:0] rnd_const(input int tw_frac);
        return (tw_frac > 0) ? (64'd1 << (tw_frac - 1)) : 64'd0;
    endfunction

    function automatic logic signed [63:0] sat_to(input logic signed [63:0] w, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (w > hi) return hi;
        if (w < lo) return lo;
        return w;
    endfunction

endpackage

// File: rtl/bfly_cmul.sv
// Pipelined complex multiplier x1*W with a final rounding register (MUL_STAGES + 1 regs).
module bfly_cmul
    import bfly_pkg::*;
#(
    parameter int DATA_W     = 30,
    parameter int TW_W       = 30,
    parameter int TW_FRAC    = TW_W - 2,
    parameter int MUL_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] x1_re_i,
    input  logic signed [DATA_W-1:0] x1_im_i,
    input  logic signed [TW_W-1:0]   w_re_i,
    input  logic signed [TW_W-1:0]   w_im_i,
    output logic signed [DATA_W:0]   p_re_o,
    output logic signed [DATA_W:0]   p_im_o
);

    localparam int PW = DATA_W + TW_W + 1;
    localparam logic signed [PW-1:0] RND = PW'(rnd_const(TW_FRAC));

    logic signed [PW-1:0] xr, xi, wr, wi, t_re_d, t_im_d, r_re, r_im;
    logic signed [PW-1:0] re_q [MUL_STAGES];
    logic signed [PW-1:0] im_q [MUL_STAGES];
    logic signed [DATA_W:0] p_re_q, p_im_q;

    assign xr = PW'(x1_re_i);
    assign xi = PW'(x1_im_i);
    assign wr = PW'(w_re_i);
    assign wi = PW'(w_im_i);

    assign t_re_d = xr * wr - xi * wi;
    assign t_im_d = xr * wi + xi * wr;

    assign r_re = re_q[MUL_STAGES-1] + RND;
    assign r_im = im_q[MUL_STAGES-1] + RND;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
            p_re_q <= '0;
            p_im_q <= '0;
        end else if (en_i) begin
            re_q[0] <= t_re_d;
            im_q[0] <= t_im_d;
            for (int i = 1; i < MUL_STAGES; i++) begin
                re_q[i] <= re_q[i-1];
                im_q[i] <= im_q[i-1];
            end
            p_re_q <= (DATA_W+1)'(r_re >>> TW_FRAC);
            p_im_q <= (DATA_W+1)'(r_im >>> TW_FRAC);
        end
    end

    assign p_re_o = p_re_q;
    assign p_im_o = p_im_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Fully pipelined radix-2 DIT butterfly with valid/ready and optional /2 scaling.
// BUTTERFLY_SAT_EN: saturate unscaled overflow and raise a sticky ovf_o flag.
module butterfly_pipe
    import bfly_pkg::*;
#(
    parameter int DATA_W     = 30,
    parameter int TW_W       = 30,
    parameter int TW_FRAC    = TW_W - 2,
    parameter int MUL_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_scale_i,
    input  logic signed [DATA_W-1:0] x0_re_i,
    input  logic signed [DATA_W-1:0] x0_im_i,
    input  logic signed [DATA_W-1:0] x1_re_i,
    input  logic signed [DATA_W-1:0] x1_im_i,
    input  logic signed [TW_W-1:0]   w_re_i,
    input  logic signed [TW_W-1:0]   w_im_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [DATA_W-1:0] y0_re_o,
    output logic signed [DATA_W-1:0] y0_im_o,
    output logic signed [DATA_W-1:0] y1_re_o,
    output logic signed [DATA_W-1:0] y1_im_o,
    output logic                     ovf_o
);

    localparam int L = latency(MUL_STAGES);

    typedef struct packed {
        logic                     sc;
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } x0_t;

    function automatic logic [DATA_W-1:0] fin(input logic signed [DATA_W:0] s, input logic sc);
        logic signed [DATA_W+1:0] r;
        r = (DATA_W+2)'(s) + (DATA_W+2)'(1);
        if (sc) return DATA_W'(r >>> 1);
`ifdef BUTTERFLY_SAT_EN
        return DATA_W'(sat_to(64'(s), DATA_W));
`else
        return DATA_W'(s);
`endif
    endfunction

    logic         stall, en, accept;
    logic [L:1]   vld_pipe_q;
    x0_t          dly_q [MUL_STAGES+1];
    x0_t          x0_in;
    logic signed [DATA_W:0] p_re, p_im, a_re, a_im;
    logic signed [DATA_W:0] s0_re, s0_im, s1_re, s1_im;
    logic signed [DATA_W-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
    logic signed [DATA_W-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;

    // Global stall: the whole pipe freezes while the output beat is refused.
    assign stall  = vld_pipe_q[L] && !out_ready_i;
    assign en     = !stall;
    assign accept = in_valid_i && en;

    assign x0_in = '{sc: in_scale_i, re: x0_re_i, im: x0_im_i};

    bfly_cmul #(
        .DATA_W    (DATA_W),
        .TW_W      (TW_W),
        .TW_FRAC   (TW_FRAC),
        .MUL_STAGES(MUL_STAGES)
    ) u_cmul (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .x1_re_i(x1_re_i),
        .x1_im_i(x1_im_i),
        .w_re_i (w_re_i),
        .w_im_i (w_im_i),
        .p_re_o (p_re),
        .p_im_o (p_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            for (int i = 0; i <= MUL_STAGES; i++) dly_q[i] <= '0;
            y0_re_q <= '0;
            y0_im_q <= '0;
            y1_re_q <= '0;
            y1_im_q <= '0;
        end else if (en) begin
            vld_pipe_q <= {vld_pipe_q[L-1:1], accept};
            dly_q[0]   <= x0_in;
            for (int i = 1; i <= MUL_STAGES; i++) dly_q[i] <= dly_q[i-1];
            y0_re_q <= y0_re_d;
            y0_im_q <= y0_im_d;
            y1_re_q <= y1_re_d;
            y1_im_q <= y1_im_d;
        end
    end

    assign a_re  = (DATA_W+1)'(dly_q[MUL_STAGES].re);
    assign a_im  = (DATA_W+1)'(dly_q[MUL_STAGES].im);
    assign s0_re = a_re + p_re;
    assign s0_im = a_im + p_im;
    assign s1_re = a_re - p_re;
    assign s1_im = a_im - p_im;

    assign y0_re_d = fin(s0_re, dly_q[MUL_STAGES].sc);
    assign y0_im_d = fin(s0_im, dly_q[MUL_STAGES].sc);
    assign y1_re_d = fin(s1_re, dly_q[MUL_STAGES].sc);
    assign y1_im_d = fin(s1_im, dly_q[MUL_STAGES].sc);

`ifdef BUTTERFLY_SAT_EN
    logic ovf_q, ovf_d;

    function automatic logic ovf_of(input logic signed [DATA_W:0] s);
        return s[DATA_W] != s[DATA_W-1];
    endfunction

    assign ovf_d = !dly_q[MUL_STAGES].sc &&
                   (ovf_of(s0_re) || ovf_of(s0_im) || ovf_of(s1_re) || ovf_of(s1_im));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else if (en && vld_pipe_q[L-1] && ovf_d) ovf_q <= 1'b1;
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    assign in_ready_o  = !stall;
    assign out_valid_o = vld_pipe_q[L];
    assign y0_re_o     = y0_re_q;
    assign y0_im_o     = y0_im_q;
    assign y1_re_o     = y1_re_q;
    assign y1_im_o     = y1_im_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe with an expected-result queue checked at the output.
module tb_butterfly_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    typedef struct {
        logic signed [DW-1:0] y0r, y0i, y1r, y1i;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, in_scale = 1'b0;
    logic signed [DW-1:0] x0_re = '0, x0_im = '0, x1_re = '0, x1_im = '0;
    logic signed [TW-1:0] w_re = '0, w_im = '0;
    logic out_valid, out_ready = 1'b1;
    logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;
    logic ovf;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    butterfly_pipe #(.DATA_W(16), .TW_W(16), .TW_FRAC(14), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_scale_i(in_scale),
        .x0_re_i(x0_re), .x0_im_i(x0_im), .x1_re_i(x1_re), .x1_im_i(x1_im),
        .w_re_i(w_re), .w_im_i(w_im),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .y0_re_o(y0_re), .y0_im_o(y0_im), .y1_re_o(y1_re), .y1_im_o(y1_im),
        .ovf_o(ovf)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrapn(input longint v, input int n);
        longint m, r;
        m = 64'sd1 <<< n;
        r = v & (m - 1);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic longint fin16(input longint v, input bit sc);
        if (sc) return wrapn((v + 1) >>> 1, 16);
`ifdef BUTTERFLY_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        return wrapn(v, 16);
`endif
    endfunction

    function automatic exp_t model(input longint a_r, a_i, b_r, b_i, c_r, c_i, input bit sc);
        exp_t e;
        longint pr, pi;
        pr = wrapn((b_r * c_r - b_i * c_i + 8192) >>> 14, 17);
        pi = wrapn((b_r * c_i + b_i * c_r + 8192) >>> 14, 17);
        e.y0r = 16'(fin16(a_r + pr, sc));
        e.y0i = 16'(fin16(a_i + pi, sc));
        e.y1r = 16'(fin16(a_r - pr, sc));
        e.y1i = 16'(fin16(a_i - pi, sc));
        return e;
    endfunction

    function automatic exp_t mk(input int a, b, c, d);
        exp_t e;
        e.y0r = 16'(a); e.y0i = 16'(b); e.y1r = 16'(c); e.y1i = 16'(d);
        return e;
    endfunction

    // Output side: every accepted output beat must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL spurious_out observed=%0d expected=none", y0_re);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("y0_re", y0_re, e.y0r);
                check("y0_im", y0_im, e.y0i);
                check("y1_re", y1_re, e.y1r);
                check("y1_im", y1_im, e.y1i);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input int a_r, a_i, b_r, b_i, c_r, c_i, input bit sc, input exp_t e);
        bit rdy;
        in_valid = 1'b1; in_scale = sc;
        x0_re = 16'(a_r); x0_im = 16'(a_i); x1_re = 16'(b_r); x1_im = 16'(b_i);
        w_re = 16'(c_r); w_im = 16'(c_i);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                sb.push_back(e);
                #1;
                return;
            end
        end
        check("send_timeout", 0, 1);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        @(posedge clk); #1;
        check("drain_left", sb.size(), 0);
    endtask

    task automatic lat_beat(input string tag);
        send(100, 50, 20, -10, 16384, 0, 1'b0, mk(120, 40, 80, 60));
        idle();
        repeat (2) @(posedge clk);
        #1 check({tag, "_early"}, out_valid, 0);
        @(posedge clk);
        #1 check({tag, "_on"}, out_valid, 1);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_y0_re", y0_re, 0);
        check("rst_y1_im", y1_im, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        lat_beat("lat");
        drain();

        send(100, 50, 20, -10, 0, -16384, 1'b0, mk(90, 30, 110, 70));
        idle();
        drain();

        send(101, -3, 0, 0, 16384, 0, 1'b1, mk(51, -1, 51, -1));
        idle();
        drain();

`ifdef BUTTERFLY_SAT_EN
        send(32767, 0, 1, 0, 16384, 0, 1'b0, mk(32767, 0, 32766, 0));
        idle();
        drain();
        check("ovf_set", ovf, 1);
        send(10, 10, 0, 0, 16384, 0, 1'b0, mk(10, 10, 10, 10));
        idle();
        drain();
        check("ovf_sticky", ovf, 1);
`else
        send(32767, 0, 1, 0, 16384, 0, 1'b0, mk(-32768, 0, 32766, 0));
        idle();
        drain();
        check("ovf_tied", ovf, 0);
`endif

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    e = model(1000 * i, -500 * i, 300 + 50 * i, -7 * i, 11585, -11585, i[0]);
                    send(1000 * i, -500 * i, 300 + 50 * i, -7 * i, 11585, -11585, i[0], e);
                end
                idle();
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check("bp_first_valid", seen, 1);
                @(posedge clk); #1 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_out_valid", out_valid, 1);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) begin
            e = model(-200 * i, 7 * i, 55, 99 - i, 16384, 16384, 1'b0);
            send(-200 * i, 7 * i, 55, 99 - i, 16384, 16384, 1'b0, e);
        end
        idle();
        @(posedge clk); #1;
        check("mid_valid_before", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_y0_re", y0_re, 0);
        check("mid_y1_im", y1_im, 0);
        check("mid_ovf", ovf, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        lat_beat("post_rst");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
